fsm_step_seq: RTL and testbench
===============================

# fsm_step_seq

Parametrised step sequencer: the next generation of the team's fixed three-state enable-stepped FSM. It walks an internal state index through `NUM_STATES` positions and advances once every `DWELL` enable pulses. It supports up/down direction, wrap or ping-pong (bounce) mode, and synchronous load. The state is presented on a registered output one cycle behind the internal state. It sits between control logic and any downstream block that consumes a phase/step index (LED patterns, mux selects, scan phases).

## Interface
- `NUM_STATES`, 3, number of positions (≥2; must fit in `DW` bits).
- `DW`, 4, width of `dout` and `load_val`.
- `DWELL`, 1, enable pulses per advance (≥1).

- `clk`  in  1  single clock; all logic rising-edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `en`  in  1  step request, sampled each cycle.
- `dir`  in  1  0 = up, 1 = down.
- `bounce`  in  1  0 = wrap mode, 1 = ping-pong mode.
- `load`  in  1  synchronous load of `load_val`.
- `load_val`  in  DW  value to load.
- `dout`  out  DW  registered copy of the internal state.
- `wrap`  out  1  one-cycle pulse marking an end-of-range turn.

## Operation
- Internal registers:
  - `cur_state` (0..NUM_STATES-1).
  - Dwell counter `cnt` (0..DWELL-1).
  - Ping-pong direction `pp_dir`.
  - `wrap_q`.
- Reset values: `cur_state`=0, `cnt`=0, `pp_dir`=0, `wrap_q`=0, `dout`=0, `wrap`=0.
- Priority per cycle: `load` > `en` > hold.
- Load:
  - `cur_state` ← `load_val` if `load_val` < NUM_STATES, else 0.
  - `cnt` ← 0, `pp_dir` ← `dir`.
  - No wrap pulse.
- Enable:
  - If `cnt` < DWELL-1: `cnt`++ and the state holds.
  - Otherwise `cnt` ← 0 and the state advances.
- Advance, wrap mode (`bounce`=0):
  - Up: +1; from NUM_STATES-1 go to 0 and set `wrap_q`.
  - Down: −1; from 0 go to NUM_STATES-1 and set `wrap_q`.
- Advance, bounce mode (`bounce`=1):
  - The state moves in direction `pp_dir`.
  - At the top moving up: go to NUM_STATES-2, `pp_dir` ← 1, set `wrap_q`.
  - At 0 moving down: go to 1, `pp_dir` ← 0, set `wrap_q`.
- `pp_dir` ← `dir` every cycle while `bounce`=0. Entering bounce mode therefore starts in the current `dir`.
- `wrap_q` is cleared on every cycle without a wrapping advance.
- Idle: `en`=0 and `load`=0 hold `cur_state` and `cnt`.
- Out-of-range `cur_state` (unreachable) is forced to 0 on the next edge; `cnt` ← 0.
- `dout` ← `cur_state` every cycle.
- `wrap` ← `wrap_q` every cycle.

## Timing
- Advance latency:
  - `cur_state` updates on the edge sampling the final `en` of a dwell.
  - `dout` reflects it one edge later.
- `wrap` is high for exactly one cycle, the same cycle `dout` first shows the turned-around value.
- `load` and `en` in the same cycle: the load wins and `en` is discarded; `cnt` restarts at 0.
- A direction or mode change mid-dwell does not reset `cnt`. It takes effect at the next advance.
- `rst_n` low mid-dwell or mid-range: all registers go to their reset values immediately. The first edge after release behaves as from a fresh reset.
- NUM_STATES=2 in bounce mode alternates 0,1,0,1 with `wrap` on every advance.

## Structure
- Shared package `fsm_step_seq_pkg`:
  - Direction constants `DIR_UP`/`DIR_DOWN`.
  - Mode constants `MODE_WRAP`/`MODE_BOUNCE`.
  - Parameter-legality check function.
- One sub-module, `fsm_dwell_cnt`:
  - Parametrised by `DWELL`.
  - Inputs: `en`, `clr`.
  - Outputs: `step` (combinational pulse when `cnt`=DWELL-1 and `en`).
  - Its `clr` is driven by `load` and by the illegal-state recovery.
- The top level holds the next-state logic, `pp_dir`, and the output registers.

## Test plan
- Defaults (3, 4, 1), `dir`=0, `bounce`=0, `en` held high 5 cycles after reset release -> `dout` 0,1,2,0,1; `wrap`=1 only in the cycle `dout` returns to 0.
- `NUM_STATES`=4, `dir`=1, `en` high 4 cycles -> `dout` 3,2,1,0 (after initial 0); `wrap` with the 3.
- `NUM_STATES`=4, `bounce`=1, `dir`=0, `en` high 8 cycles -> `dout` 1,2,3,2,1,0,1,2; `wrap` pulses with the first 2 after 3 and with the 1 after 0.
- `DWELL`=3, `en` pulsed 6 times non-contiguously -> `dout` steps 0→1→2 only after the 3rd and 6th pulse; idle gaps hold `cnt`.
- `load`=1 with `load_val`=2 and `en`=1 together, then `load_val`=7 with `NUM_STATES`=3 -> `dout` 2, then 0; no `wrap`; `cnt` restarted.
- `rst_n` pulsed low mid-dwell with state 2, `pp_dir`=1 -> `dout`=0 and `wrap`=0 asynchronously; after release the next advance is 0→1 after a full dwell.

Source files
------------

// File: rtl/fsm_step_seq_pkg.sv
// Shared constants and the parameter-legality check for the step sequencer.
package fsm_step_seq_pkg;

    localparam logic DIR_UP      = 1'b0;
    localparam logic DIR_DOWN    = 1'b1;
    localparam logic MODE_WRAP   = 1'b0;
    localparam logic MODE_BOUNCE = 1'b1;

    function automatic bit params_legal(int num_states, int dw, int dwell);
        return (dw >= 1) && (num_states >= 2) && (num_states <= (1 << dw)) && (dwell >= 1);
    endfunction

endpackage

// File: rtl/fsm_step_seq_if.sv
// Control and output bundle of the step sequencer.
interface fsm_step_seq_if #(
    parameter int DW = 4
);
    // No valid/ready pair: en and load are sampled on every rising edge with
    // load winning; dout/wrap are valid on every cycle and never stall.
    logic          en;
    logic          dir;
    logic          bounce;
    logic          load;
    logic [DW-1:0] load_val;
    logic [DW-1:0] dout;
    logic          wrap;
    logic [DW-1:0] dbg_state;

    modport master (
        output en, dir, bounce, load, load_val,
        input  dout, wrap, dbg_state
    );

    modport slave (
        input  en, dir, bounce, load, load_val,
        output dout, wrap, dbg_state
    );
endinterface

// File: rtl/fsm_dwell_cnt.sv
// Dwell counter: emits a step pulse on the DWELL-th enable since the last clear.
module fsm_dwell_cnt #(
    parameter int DWELL = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic step
);
    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

    logic [CW-1:0] cnt;

    assign step = en && (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
        end
    end
endmodule

// File: rtl/fsm_step_seq.sv
// Step sequencer top: next-state logic, ping-pong direction and output registers.
module fsm_step_seq
    import fsm_step_seq_pkg::*;
#(
    parameter int NUM_STATES = 3,
    parameter int DW         = 4,
    parameter int DWELL      = 1
) (
    input logic          clk,
    input logic          rst_n,
    fsm_step_seq_if.slave bus
);
    if (!params_legal(NUM_STATES, DW, DWELL)) begin : g_param_check
        $error("fsm_step_seq: illegal NUM_STATES/DW/DWELL combination");
    end

    localparam logic [DW:0]   NS_EXT    = (DW + 1)'(NUM_STATES);
    localparam logic [DW-1:0] TOP       = DW'(NUM_STATES - 1);
    localparam logic [DW-1:0] BELOW_TOP = DW'(NUM_STATES - 2);

    logic [DW-1:0] cur_state, nxt_state;
    logic          pp_dir, nxt_pp;
    logic          wrap_q, nxt_wrap;
    logic [DW-1:0] dout_q;
    logic          wrap_out;
    logic          step, illegal, load_ok, dwell_clr;

    assign illegal   = {1'b0, cur_state} >= NS_EXT;
    assign load_ok   = {1'b0, bus.load_val} < NS_EXT;
    assign dwell_clr = bus.load | illegal;

    fsm_dwell_cnt #(.DWELL(DWELL)) u_dwell (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (bus.en),
        .clr   (dwell_clr),
        .step  (step)
    );

    always_comb begin
        nxt_state = cur_state;
        nxt_pp    = pp_dir;
        nxt_wrap  = 1'b0;
        if (bus.bounce == MODE_WRAP) nxt_pp = bus.dir;

        if (bus.load) begin
            nxt_state = load_ok ? bus.load_val : '0;
            nxt_pp    = bus.dir;
        end else if (illegal) begin
            nxt_state = '0;
        end else if (step) begin
            if (bus.bounce == MODE_WRAP) begin
                if (bus.dir == DIR_UP) begin
                    if (cur_state == TOP) begin
                        nxt_state = '0;
                        nxt_wrap  = 1'b1;
                    end else begin
                        nxt_state = cur_state + DW'(1);
                    end
                end else if (cur_state == '0) begin
                    nxt_state = TOP;
                    nxt_wrap  = 1'b1;
                end else begin
                    nxt_state = cur_state - DW'(1);
                end
            end else begin
                // Bounce turns around at either end, so the end value is shown once.
                if (pp_dir == DIR_UP) begin
                    if (cur_state == TOP) begin
                        nxt_state = BELOW_TOP;
                        nxt_pp    = DIR_DOWN;
                        nxt_wrap  = 1'b1;
                    end else begin
                        nxt_state = cur_state + DW'(1);
                    end
                end else if (cur_state == '0) begin
                    nxt_state = DW'(1);
                    nxt_pp    = DIR_UP;
                    nxt_wrap  = 1'b1;
                end else begin
                    nxt_state = cur_state - DW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_state <= '0;
            pp_dir    <= 1'b0;
            wrap_q    <= 1'b0;
            dout_q    <= '0;
            wrap_out  <= 1'b0;
        end else begin
            cur_state <= nxt_state;
            pp_dir    <= nxt_pp;
            wrap_q    <= nxt_wrap;
            dout_q    <= cur_state;
            wrap_out  <= wrap_q;
        end
    end

    assign bus.dout      = dout_q;
    assign bus.wrap      = wrap_out;
    assign bus.dbg_state = cur_state;
endmodule

// File: tb/tb_fsm_step_seq.sv
// Bench for fsm_step_seq: four configurations share one stimulus stream.
module tb_fsm_step_seq;
    localparam int DW    = 4;
    localparam int N_DUT = 4;
    localparam int SW    = 2 * DW + 1;
    localparam int W     = N_DUT * SW;
    localparam int NS_P    [N_DUT] = '{3, 4, 3, 2};
    localparam int DWELL_P [N_DUT] = '{1, 1, 3, 2};

    logic          clk;
    logic          rst_n;
    logic          en, dir, bounce, load;
    logic [DW-1:0] load_val;
    logic [SW-1:0] obs [N_DUT];

    logic [W-1:0] exp_q [$];
    int n_cmp = 0;
    int n_err = 0;

    int m_cur  [N_DUT];
    int m_cnt  [N_DUT];
    bit m_pp   [N_DUT];
    bit m_wq   [N_DUT];
    int m_dout [N_DUT];
    bit m_wrap [N_DUT];

    for (genvar g = 0; g < N_DUT; g++) begin : g_dut
        fsm_step_seq_if #(.DW(DW)) bus ();
        fsm_step_seq #(
            .NUM_STATES (NS_P[g]),
            .DW         (DW),
            .DWELL      (DWELL_P[g])
        ) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus)
        );
        assign bus.en       = en;
        assign bus.dir      = dir;
        assign bus.bounce   = bounce;
        assign bus.load     = load;
        assign bus.load_val = load_val;
        assign obs[g]       = {bus.dbg_state, bus.wrap, bus.dout};
    end

    // Clock and reset defaults
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: position on a line of ns slots, stepping by +/-1;
    // wrap mode takes the result modulo ns, bounce mode reflects off the ends.
    function automatic void model_reset();
        for (int g = 0; g < N_DUT; g++) begin
            m_cur[g] = 0; m_cnt[g] = 0; m_pp[g] = 1'b0;
            m_wq[g] = 1'b0; m_dout[g] = 0; m_wrap[g] = 1'b0;
        end
    endfunction

    function automatic void model_edge(int g, bit e, bit d, bit b, bit ld, int lv);
        int ns = NS_P[g];
        int nxt;
        int delta;
        m_dout[g] = m_cur[g];
        m_wrap[g] = m_wq[g];
        m_wq[g]   = 1'b0;
        if (ld) begin
            m_cur[g] = (lv < ns) ? lv : 0;
            m_cnt[g] = 0;
            m_pp[g]  = d;
            return;
        end
        if (e) begin
            if (m_cnt[g] < DWELL_P[g] - 1) begin
                m_cnt[g]++;
            end else begin
                m_cnt[g] = 0;
                if (!b) begin
                    nxt = d ? m_cur[g] - 1 : m_cur[g] + 1;
                    if (nxt < 0 || nxt >= ns) begin
                        nxt = (nxt + ns) % ns;
                        m_wq[g] = 1'b1;
                    end
                end else begin
                    delta = m_pp[g] ? -1 : 1;
                    nxt = m_cur[g] + delta;
                    if (nxt < 0 || nxt >= ns) begin
                        nxt = m_cur[g] - delta;
                        m_pp[g] = !m_pp[g];
                        m_wq[g] = 1'b1;
                    end
                end
                m_cur[g] = nxt;
            end
        end
        if (!b) m_pp[g] = d;
    endfunction

    // Driver tasks: entered and left on a falling edge
    task automatic drive(bit e, bit d, bit b, bit ld, int lv);
        logic [W-1:0] exp_word;
        en = e; dir = d; bounce = b; load = ld; load_val = DW'(lv);
        for (int g = 0; g < N_DUT; g++) begin
            model_edge(g, e, d, b, ld, lv);
            exp_word[g*SW +: SW] = {DW'(m_cur[g]), m_wrap[g], DW'(m_dout[g])};
        end
        exp_q.push_back(exp_word);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_zero(string name);
        for (int g = 0; g < N_DUT; g++) begin
            n_cmp++;
            if (obs[g] !== '0) begin
                n_err++;
                $display("FAIL %s dut%0d: got state=%0d wrap=%0b dout=%0d, expected all 0",
                         name, g, obs[g][2*DW:DW+1], obs[g][DW], obs[g][DW-1:0]);
            end
        end
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #1;
        check_zero("async_reset");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Scoreboard monitor: one expected word per rising edge that had stimulus
    initial begin
        logic [W-1:0] exp_word;
        logic [SW-1:0] e_f;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                exp_word = exp_q.pop_front();
                for (int g = 0; g < N_DUT; g++) begin
                    e_f = exp_word[g*SW +: SW];
                    n_cmp++;
                    if (obs[g] !== e_f) begin
                        n_err++;
                        $display("FAIL step dut%0d t=%0t: got state=%0d wrap=%0b dout=%0d, expected state=%0d wrap=%0b dout=%0d",
                                 g, $time, obs[g][2*DW:DW+1], obs[g][DW], obs[g][DW-1:0],
                                 e_f[2*DW:DW+1], e_f[DW], e_f[DW-1:0]);
                    end
                end
            end
        end
    end

    // Stimulus
    initial begin
        bit r_dir;
        bit r_bounce;
        rst_n = 1'b0;
        en = 1'b0; dir = 1'b0; bounce = 1'b0; load = 1'b0; load_val = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;

        repeat (5) drive(1, 0, 0, 0, 0);
        repeat (2) drive(0, 0, 0, 0, 0);
        repeat (4) drive(1, 1, 0, 0, 0);
        drive(0, 0, 0, 1, 0);
        repeat (8) drive(1, 0, 1, 0, 0);
        drive(0, 0, 0, 1, 0);
        for (int p = 0; p < 6; p++) begin
            drive(1, 0, 0, 0, 0);
            repeat ($urandom_range(1, 3)) drive(0, 0, 0, 0, 0);
        end
        drive(1, 0, 0, 1, 2);
        drive(0, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 7);
        repeat (2) drive(0, 0, 0, 0, 0);

        drive(0, 1, 1, 1, 2);
        drive(1, 1, 1, 0, 0);
        pulse_reset();
        repeat (6) drive(1, 0, 0, 0, 0);

        r_dir = 1'b0;
        r_bounce = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 9) == 0) r_dir = !r_dir;
            if ($urandom_range(0, 19) == 0) r_bounce = !r_bounce;
            if ($urandom_range(0, 149) == 0) pulse_reset();
            drive($urandom_range(0, 9) < 7, r_dir, r_bounce,
                  $urandom_range(0, 19) == 0, int'($urandom_range(0, 15)));
        end

        repeat (2) @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d unchecked entries, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
